// File: rtl/svd_pkg.sv
// svd_pkg: widths, capture length and collector state encoding shared by the SVD datapath
package svd_pkg;

    localparam int UV_W   = 8;
    localparam int S_W    = 14;
    localparam int N_ELEM = 4;
    localparam int N_CAPT = 8;

    typedef enum logic [1:0] {IDLE, REQ, CAPT, DONE} collect_state_t;

endpackage

// File: rtl/svd_result_collector_if.sv
// svd_result_collector_if: readout stream from the SVD interface plus the result/ack handshake to the consumer
interface svd_result_collector_if #(
    parameter int UV_W = svd_pkg::UV_W,
    parameter int S_W  = svd_pkg::S_W
);

    logic                   ready;
    logic [UV_W-1:0]        data_o_UV;
    logic [S_W/2-1:0]       data_o_S;
    logic                   oe;
    logic [1:0]             element_sel;
    logic                   busy;
    logic signed [UV_W-1:0] u0, u1, u2, u3;
    logic signed [UV_W-1:0] v0, v1, v2, v3;
    logic signed [S_W-1:0]  s0, s1, s2, s3;
    logic                   result_valid;
    logic                   result_ack;

    modport master (
        input  ready, data_o_UV, data_o_S, result_ack,
        output oe, element_sel, busy, result_valid,
        output u0, u1, u2, u3, v0, v1, v2, v3, s0, s1, s2, s3
    );

    modport slave (
        output ready, data_o_UV, data_o_S, result_ack,
        input  oe, element_sel, busy, result_valid,
        input  u0, u1, u2, u3, v0, v1, v2, v3, s0, s1, s2, s3
    );

endinterface

// File: rtl/svd_result_collector.sv
// svd_result_collector: requests SVD readout and reassembles the multiplexed U/V/S stream into parallel registers
module svd_result_collector
    import svd_pkg::*;
#(
    parameter int UV_W = svd_pkg::UV_W,
    parameter int S_W  = svd_pkg::S_W
) (
    input  logic                   clk,
    input  logic                   rst,
    svd_result_collector_if.master bus
);

    localparam int H = S_W / 2;

    collect_state_t         state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   ready_q;
    logic                   oe_q, oe_d;
    logic signed [UV_W-1:0] u_q [N_ELEM];
    logic signed [UV_W-1:0] u_d [N_ELEM];
    logic signed [UV_W-1:0] v_q [N_ELEM];
    logic signed [UV_W-1:0] v_d [N_ELEM];
    logic signed [S_W-1:0]  s_q [N_ELEM];
    logic signed [S_W-1:0]  s_d [N_ELEM];
    logic [1:0]             sel;

    assign sel = cnt_q[2:1];

    // Next state and capture: even beats carry U and the S low half, odd beats V and the S high half
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        u_d     = u_q;
        v_d     = v_q;
        s_d     = s_q;
        case (state_q)
            IDLE: state_d = (bus.ready & ~ready_q) ? REQ : IDLE;
            REQ: begin
                state_d = CAPT;
                cnt_d   = '0;
            end
            CAPT: begin
                cnt_d   = cnt_q + 3'd1;
                state_d = (cnt_q == 3'(N_CAPT - 1)) ? DONE : CAPT;
                if (cnt_q[0]) begin
                    v_d[sel]          = bus.data_o_UV;
                    s_d[sel][S_W-1:H] = bus.data_o_S;
                end else begin
                    u_d[sel]        = bus.data_o_UV;
                    s_d[sel][H-1:0] = bus.data_o_S;
                end
            end
            DONE: state_d = bus.result_ack ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        oe_d = (state_d == REQ);
    end

    // State, edge-detect history, registered oe and element storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            oe_q    <= 1'b0;
            u_q     <= '{default: '0};
            v_q     <= '{default: '0};
            s_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= bus.ready;
            oe_q    <= oe_d;
            u_q     <= u_d;
            v_q     <= v_d;
            s_q     <= s_d;
        end
    end

    assign bus.oe           = oe_q;
    assign bus.busy         = (state_q == REQ) || (state_q == CAPT);
    assign bus.element_sel  = (state_q == CAPT) ? sel : 2'd0;
    assign bus.result_valid = (state_q == DONE);
    assign bus.u0 = u_q[0];
    assign bus.u1 = u_q[1];
    assign bus.u2 = u_q[2];
    assign bus.u3 = u_q[3];
    assign bus.v0 = v_q[0];
    assign bus.v1 = v_q[1];
    assign bus.v2 = v_q[2];
    assign bus.v3 = v_q[3];
    assign bus.s0 = s_q[0];
    assign bus.s1 = s_q[1];
    assign bus.s2 = s_q[2];
    assign bus.s3 = s_q[3];

endmodule

// File: tb/tb_svd_result_collector.sv
// tb_svd_result_collector: directed checks of the SVD result collector against a stream model of the interface
module tb_svd_result_collector;
    import svd_pkg::*;

    localparam int H = S_W / 2;

    typedef struct {
        logic       rdy;
        logic       ack;
        logic       oe;
        logic       busy;
        logic       vld;
        logic [1:0] sel;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [UV_W-1:0] eu [4];
    logic [UV_W-1:0] ev [4];
    logic [S_W-1:0]  es [4];
    logic [3:0]      ph;
    vec_t            tv [13];
    int              oe_cnt;

    always #5 clk = ~clk;

    svd_result_collector_if #(.UV_W(UV_W), .S_W(S_W)) bus ();

    svd_result_collector #(.UV_W(UV_W), .S_W(S_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Interface model: output phase starts the cycle after oe and walks 8 beats
    always @(posedge clk) ph <= rst ? 4'd8 : bus.oe ? 4'd0 : (ph < 4'd8) ? ph + 4'd1 : ph;

    always_comb begin
        bus.data_o_UV = '0;
        bus.data_o_S  = '0;
        if (ph < 4'd8) begin
            bus.data_o_UV = ph[0] ? ev[ph[2:1]] : eu[ph[2:1]];
            bus.data_o_S  = ph[0] ? es[ph[2:1]][S_W-1:H] : es[ph[2:1]][H-1:0];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic oe, input logic busy, input logic vld, input logic [1:0] sel);
        chk({tag, " oe"}, 32'(bus.oe), 32'(oe));
        chk({tag, " busy"}, 32'(bus.busy), 32'(busy));
        chk({tag, " valid"}, 32'(bus.result_valid), 32'(vld));
        chk({tag, " sel"}, 32'(bus.element_sel), 32'(sel));
    endtask

    task automatic chk_res(input string tag);
        logic [UV_W-1:0] gu [4];
        logic [UV_W-1:0] gv [4];
        logic [S_W-1:0]  gs [4];
        gu = '{bus.u0, bus.u1, bus.u2, bus.u3};
        gv = '{bus.v0, bus.v1, bus.v2, bus.v3};
        gs = '{bus.s0, bus.s1, bus.s2, bus.s3};
        for (int e = 0; e < 4; e++) begin
            chk($sformatf("%s u%0d", tag, e), 32'(gu[e]), 32'(eu[e]));
            chk($sformatf("%s v%0d", tag, e), 32'(gv[e]), 32'(ev[e]));
            chk($sformatf("%s s%0d", tag, e), 32'(gs[e]), 32'(es[e]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rdy, ack, oe, busy, vld, sel per cycle starting at the ready rise t
        tv = '{
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
            '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3},
            '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3},
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0},
            '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}
        };
        rst = 1'b1;
        bus.ready = 1'b0;
        bus.result_ack = 1'b0;
        eu = '{default: '0};
        ev = '{default: '0};
        es = '{default: '0};
        tick();
        tick();
        tick();
        chk_ctl("reset", 1'b0, 1'b0, 1'b0, 2'd0);
        chk_res("reset");
        rst = 1'b0;
        tick();

        // Single result driven from the cycle table, ready held high throughout
        eu = '{8'h10, 8'h20, 8'h30, 8'h40};
        ev = '{8'hF0, 8'hE0, 8'hD0, 8'hC0};
        es = '{14'h1ABC, 14'h0123, 14'h3FFF, 14'h2000};
        for (int i = 0; i < 13; i++) begin
            tick();
            chk_ctl($sformatf("single t+%0d", i), tv[i].oe, tv[i].busy, tv[i].vld, tv[i].sel);
            bus.ready = tv[i].rdy;
            bus.result_ack = tv[i].ack;
        end
        chk_res("single");

        // Level held for 50 cycles: one oe pulse, ack at t+12, no retrigger
        bus.ready = 1'b0;
        tick();
        tick();
        tick();
        bus.ready = 1'b1;
        oe_cnt = 0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            oe_cnt += int'(bus.oe);
            if (c == 12) begin
                chk("held valid t+12", 32'(bus.result_valid), 32'd1);
                bus.result_ack = 1'b1;
            end
            if (c == 13) begin
                bus.result_ack = 1'b0;
                chk_ctl("held t+13", 1'b0, 1'b0, 1'b0, 2'd0);
            end
        end
        chk("held oe pulses", 32'(oe_cnt), 32'd1);
        chk_res("held");

        // Delayed ack with a second ready edge while DONE
        bus.ready = 1'b0;
        tick();
        eu = '{8'h7F, 8'h80, 8'h01, 8'hFF};
        ev = '{8'h55, 8'hAA, 8'h00, 8'h11};
        es = '{14'h0001, 14'h3FFE, 14'h2AAA, 14'h1555};
        tick();
        bus.ready = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c >= 10 && c <= 30) chk($sformatf("delay valid t+%0d", c), 32'(bus.result_valid), 32'd1);
            if (c == 11) bus.ready = 1'b0;
            if (c == 13) bus.ready = 1'b1;
            if (c == 20) chk_res("delay mid");
            if (c == 30) begin
                chk_res("delay end");
                bus.result_ack = 1'b1;
            end
            if (c == 31) begin
                bus.result_ack = 1'b0;
                chk_ctl("delay t+31", 1'b0, 1'b0, 1'b0, 2'd0);
            end
            if (c > 31) chk($sformatf("delay no oe t+%0d", c), 32'(bus.oe), 32'd0);
        end

        // Reset mid capture, then a fresh full result
        bus.ready = 1'b0;
        tick();
        eu = '{8'h01, 8'h02, 8'h03, 8'h04};
        ev = '{8'h05, 8'h06, 8'h07, 8'h08};
        es = '{14'h0AAA, 14'h0BBB, 14'h0CCC, 14'h0DDD};
        tick();
        bus.ready = 1'b1;
        for (int c = 1; c <= 5; c++) tick();
        chk("rst busy t+5", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        bus.ready = 1'b0;
        tick();
        rst = 1'b0;
        chk_ctl("after rst", 1'b0, 1'b0, 1'b0, 2'd0);
        eu = '{default: '0};
        ev = '{default: '0};
        es = '{default: '0};
        chk_res("after rst");
        eu = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        ev = '{8'h1A, 8'h2B, 8'h3C, 8'h4D};
        es = '{14'h3F00, 14'h00FF, 14'h2345, 14'h1234};
        tick();
        tick();
        bus.ready = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        chk("fresh valid t+10", 32'(bus.result_valid), 32'd1);
        chk_res("fresh");

        // Back-to-back: ack at t+10, next ready rise at t+11
        bus.result_ack = 1'b1;
        bus.ready = 1'b0;
        tick();
        bus.result_ack = 1'b0;
        chk("b2b valid dropped", 32'(bus.result_valid), 32'd0);
        bus.ready = 1'b1;
        eu = '{8'h66, 8'h77, 8'h88, 8'h99};
        ev = '{8'h9A, 8'h8B, 8'h7C, 8'h6D};
        es = '{14'h2001, 14'h1FFE, 14'h0F0F, 14'h30C3};
        for (int c = 12; c <= 21; c++) begin
            tick();
            if (c == 20) chk("b2b valid t+20", 32'(bus.result_valid), 32'd0);
        end
        chk("b2b valid t+21", 32'(bus.result_valid), 32'd1);
        chk_res("b2b");
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        chk("b2b final idle", 32'(bus.result_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
